// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU memory responder: boot-load FSM, 256x16 RAM, LED register, switch input
module mem_responder #(
    parameter int         RAM_WORDS = 256,
    parameter logic [8:0] LED_ADDR  = 9'h100,
    parameter logic [8:0] SW_ADDR   = 9'h140,
    parameter bit         SKIP_LOAD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    input  logic [7:0]  SW,
    output logic [7:0]  LEDR,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic        load_last,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        bad_access
);

    localparam int            AW       = $clog2(RAM_WORDS);
    localparam logic [AW-1:0] LAST_PTR = AW'(RAM_WORDS - 1);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_load_ptr;
    logic [15:0]   r_mem [0:RAM_WORDS-1];
    logic [15:0]   r_read_data;
    logic [7:0]    r_led;
    logic          r_bad;
    logic [7:0]    r_sw_meta;
    logic [7:0]    r_sw_sync;

    logic          w_in_ram;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_waddr;
    logic [15:0]   w_mem_wdata;

    assign w_in_ram = ~mem_addr[8];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SKIP_LOAD ? ST_RUN : ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A load ends on the flagged last word or when the pointer is about to wrap.
    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_LOAD && load_valid && (load_last || r_load_ptr == LAST_PTR)) begin
            w_state_next = ST_RUN;
        end
    end

    always_comb begin
        cpu_reset = (r_state == ST_LOAD);
        load_done = (r_state == ST_RUN);
    end

    // Reset has priority over both boot-load and CPU writes.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = mem_addr[AW-1:0];
        w_mem_wdata = write_data;
        if (!reset) begin
            if (r_state == ST_LOAD) begin
                w_mem_we    = load_valid;
                w_mem_waddr = r_load_ptr;
                w_mem_wdata = load_data;
            end else begin
                w_mem_we = (mem_cmd == CMD_WRITE) && w_in_ram;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data <= 16'h0000;
            r_led       <= 8'h00;
            r_bad       <= 1'b0;
            r_load_ptr  <= '0;
        end else if (r_state == ST_LOAD) begin
            r_read_data <= 16'h0000;
            if (load_valid) begin
                r_load_ptr <= r_load_ptr + AW'(1);
            end
        end else begin
            case (mem_cmd)
                CMD_NONE: ;
                CMD_READ: begin
                    if (w_in_ram) begin
                        r_read_data <= r_mem[mem_addr[AW-1:0]];
                    end else if (mem_addr == SW_ADDR) begin
                        r_read_data <= {8'h00, r_sw_sync};
                    end else begin
                        r_read_data <= 16'h0000;
                        r_bad       <= 1'b1;
                    end
                end
                CMD_WRITE: begin
                    if (!w_in_ram) begin
                        if (mem_addr == LED_ADDR) begin
                            r_led <= write_data[7:0];
                        end else begin
                            r_bad <= 1'b1;
                        end
                    end
                end
                default: r_bad <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign read_data  = r_read_data;
    assign LEDR       = r_led;
    assign bad_access = r_bad;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed plus randomized bench for mem_responder against a behavioural model
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic [7:0]  SW;
    logic [7:0]  LEDR;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        cpu_reset;
    logic        load_done;
    logic        bad_access;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_mem [256];
    bit          m_loading;
    int          m_ptr;
    logic [15:0] m_rd;
    logic [7:0]  m_led;
    bit          m_bad;
    logic [7:0]  m_swq [$];

    always #5 clk = ~clk;

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .SW         (SW),
        .LEDR       (LEDR),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .bad_access (bad_access)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: switches are seen by reads two edges late; a read uses the oldest queued sample.
    task automatic model_edge();
        if (reset) begin
            m_loading = 1'b1;
            m_ptr     = 0;
            m_rd      = 16'h0000;
            m_led     = 8'h00;
            m_bad     = 1'b0;
            m_swq     = {8'h00, 8'h00};
        end else begin
            if (m_loading) begin
                m_rd = 16'h0000;
                if (load_valid) begin
                    m_mem[m_ptr] = load_data;
                    if (load_last || m_ptr == 255) m_loading = 1'b0;
                    m_ptr = (m_ptr + 1) % 256;
                end
            end else begin
                case (mem_cmd)
                    2'b01: begin
                        if (mem_addr < 9'd256) m_rd = m_mem[mem_addr[7:0]];
                        else if (mem_addr == 9'h140) m_rd = {8'h00, m_swq[0]};
                        else begin
                            m_rd  = 16'h0000;
                            m_bad = 1'b1;
                        end
                    end
                    2'b10: begin
                        if (mem_addr < 9'd256) m_mem[mem_addr[7:0]] = write_data;
                        else if (mem_addr == 9'h100) m_led = write_data[7:0];
                        else m_bad = 1'b1;
                    end
                    2'b11: m_bad = 1'b1;
                    default: ;
                endcase
            end
            m_swq.push_back(SW);
            void'(m_swq.pop_front());
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("read_data", read_data, m_rd);
        chk("LEDR", {8'h00, LEDR}, {8'h00, m_led});
        chk("bad_access", {15'h0, bad_access}, {15'h0, m_bad});
        chk("cpu_reset", {15'h0, cpu_reset}, {15'h0, m_loading});
        chk("load_done", {15'h0, load_done}, {15'h0, !m_loading});
    endtask

    task automatic idle();
        reset      = 1'b0;
        mem_cmd    = 2'b00;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = data;
        step();
        mem_cmd    = 2'b00;
    endtask

    task automatic load_words(input int n, input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = 16'($urandom);
            load_last  = last_on_final && (i == n - 1);
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    logic [15:0] boot_words [4];
    logic [15:0] w0, w1;

    initial begin
        boot_words = '{16'hD105, 16'hD202, 16'hA023, 16'hE000};
        reset = 1'b1; mem_cmd = 2'b00; mem_addr = 9'h000; write_data = 16'h0000;
        SW = 8'h00; load_valid = 1'b0; load_data = 16'h0000; load_last = 1'b0;

        // Reset state
        step();
        step();
        chk("reset_load_ptr", {8'h00, dut.r_load_ptr}, 16'h0000);
        chk("reset_cpu_reset", {15'h0, cpu_reset}, 16'h0001);
        idle();

        // 256-word load with no load_last
        load_words(256, 1'b0);
        chk("wrap_load_ptr", {8'h00, dut.r_load_ptr}, 16'h0000);
        chk("wrap_load_done", {15'h0, load_done}, 16'h0001);
        load_valid = 1'b1;
        load_data  = ~m_mem[0];
        step();
        load_valid = 1'b0;
        bus(2'b01, 9'h000, 16'h0000);
        chk("word257_ignored", {15'h0, read_data != ~m_mem[0]}, 16'h0001);

        // Boot load of four words
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = boot_words[i];
            load_last  = (i == 3);
            step();
            chk("boot_cpu_reset", {15'h0, cpu_reset}, (i == 3) ? 16'h0000 : 16'h0001);
        end
        idle();
        chk("boot_load_ptr", {8'h00, dut.r_load_ptr}, 16'h0004);
        for (int i = 0; i < 4; i++) begin
            bus(2'b01, 9'(i), 16'h0000);
            chk("boot_word", read_data, boot_words[i]);
        end

        // Read latency and hold
        bus(2'b10, 9'h010, 16'hBEEF);
        bus(2'b01, 9'h010, 16'h0000);
        chk("read_beef", read_data, 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_beef", read_data, 16'hBEEF);
        end

        // LED and switches
        bus(2'b10, 9'h100, 16'h12A5);
        chk("led_a5", {8'h00, LEDR}, 16'h00A5);
        SW = 8'h3C;
        step();
        step();
        bus(2'b01, 9'h140, 16'h0000);
        chk("sw_3c", read_data, 16'h003C);
        SW = 8'h81;
        bus(2'b01, 9'h140, 16'h0000);
        chk("sw_edge_n", read_data, 16'h003C);
        bus(2'b01, 9'h140, 16'h0000);
        chk("sw_edge_n1", read_data, 16'h003C);
        bus(2'b01, 9'h140, 16'h0000);
        chk("sw_edge_n2", read_data, 16'h0081);

        // Unmapped accesses
        chk("bad_before", {15'h0, bad_access}, 16'h0000);
        bus(2'b01, 9'h1FF, 16'h0000);
        chk("bad_read_data", read_data, 16'h0000);
        chk("bad_read_flag", {15'h0, bad_access}, 16'h0001);
        bus(2'b10, 9'h180, 16'h5A5A);
        chk("bad_write_led", {8'h00, LEDR}, 16'h00A5);
        bus(2'b01, 9'h080, 16'h0000);
        chk("bad_write_ram", read_data, m_mem[8'h80]);
        step();
        chk("bad_sticky", {15'h0, bad_access}, 16'h0001);
        reset = 1'b1;
        step();
        reset = 1'b0;
        load_words(1, 1'b1);
        chk("bad_cleared", {15'h0, bad_access}, 16'h0000);
        bus(2'b11, 9'h000, 16'hFFFF);
        chk("bad_illegal_cmd", {15'h0, bad_access}, 16'h0001);

        // Randomized bus traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) SW = 8'($urandom);
            case ($urandom_range(0, 5))
                0, 1, 2: mem_addr = {1'b0, 8'($urandom)};
                3:       mem_addr = 9'h100;
                4:       mem_addr = 9'h140;
                default: mem_addr = 9'($urandom);
            endcase
            mem_cmd    = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            write_data = 16'($urandom);
            step();
        end
        idle();

        // Reset suppresses a RUN-state write in the same cycle
        reset = 1'b1; mem_cmd = 2'b10; mem_addr = 9'h020; write_data = ~m_mem[32];
        step();
        idle();
        chk("run_write_suppressed", dut.r_mem[32], m_mem[32]);

        // Reset mid-load with a word offered in the reset cycle
        load_words(2, 1'b0);
        w0 = m_mem[0];
        w1 = m_mem[1];
        reset = 1'b1; load_valid = 1'b1; load_data = ~m_mem[2];
        step();
        idle();
        chk("midload_ptr", {8'h00, dut.r_load_ptr}, 16'h0000);
        chk("midload_cpu_reset", {15'h0, cpu_reset}, 16'h0001);
        chk("midload_ram0", dut.r_mem[0], w0);
        chk("midload_ram1", dut.r_mem[1], w1);
        chk("midload_ram2", dut.r_mem[2], m_mem[2]);
        load_words(3, 1'b1);
        for (int i = 0; i < 3; i++) bus(2'b01, 9'(i), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's `mem_cmd`/`mem_addr` bus. It holds a 256×16 synchronous RAM, a memory-mapped LED output register and a synchronised switch input. It also contains a boot-load state machine: after reset, the machine fills RAM from an external word stream while holding the CPU in reset, then releases the CPU. The block sits beside `cpu` at the top level and drives its `read_data`.

## Interface
- `RAM_WORDS`, default 256: RAM depth; word address is `mem_addr[7:0]`.
- `LED_ADDR`, default 9'h100: write-only LED register address.
- `SW_ADDR`, default 9'h140: read-only switch address.
- `SKIP_LOAD`, default 0: when 1, reset goes directly to RUN and skips boot load.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_cmd`  in  2  2'b00 none, 2'b01 MREAD, 2'b10 MWRITE, 2'b11 illegal.
- `mem_addr`  in  9  CPU word address.
- `write_data`  in  16  CPU store data.
- `read_data`  out  16  registered read data to the CPU.
- `SW`  in  8  asynchronous switches.
- `LEDR`  out  8  LED register.
- `load_valid`  in  1  boot word present this cycle.
- `load_data`  in  16  boot word.
- `load_last`  in  1  qualifies the final boot word (valid only with `load_valid`).
- `cpu_reset`  out  1  registered reset to the CPU.
- `load_done`  out  1  high once boot load has completed.
- `bad_access`  out  1  sticky unmapped or illegal access flag.

## Operation
- States are LOAD and RUN.
  - Reset enters LOAD, or RUN if `SKIP_LOAD`=1.
  - Reset clears: `load_ptr`=0, `read_data`=0, `LEDR`=0, `bad_access`=0, `load_done`=0 (or 1 if `SKIP_LOAD`), `cpu_reset`=1 (or 0 if `SKIP_LOAD`), and both switch sync flops.
  - RAM contents are not cleared by reset.
- LOAD state:
  - Each cycle with `load_valid`=1 writes RAM[`load_ptr`] ← `load_data` and increments `load_ptr` (8-bit).
  - The state moves to RUN on the edge that writes a word with `load_last`=1, or the word at `load_ptr`=255.
  - `load_ptr` wraps to 0 when that happens.
  - The CPU bus is ignored; `read_data` holds 0.
  - `load_valid` is ignored in RUN.
- RUN state: `cpu_reset`=0 and `load_done`=1. Bus decode is evaluated every cycle:
  - MREAD with `mem_addr[8]`=0: `read_data` ← RAM[`mem_addr[7:0]`].
  - MREAD at `SW_ADDR`: `read_data` ← {8'h00, switch sync stage 2}.
  - MREAD at any other address: `read_data` ← 0 and `bad_access` ← 1.
  - MWRITE with `mem_addr[8]`=0: RAM[`mem_addr[7:0]`] ← `write_data`.
  - MWRITE at `LED_ADDR`: `LEDR` ← `write_data[7:0]`.
  - MWRITE at any other address: nothing is written and `bad_access` ← 1.
  - `mem_cmd`=2'b11: no state change except `bad_access` ← 1.
  - `mem_cmd`=2'b00: `read_data` holds its last value.
- `bad_access` is cleared only by reset.
- Switches pass through a 2-flop synchroniser that runs in both states.

## Timing
- Read latency is 1 cycle. MREAD is sampled at edge N and `read_data` is valid after edge N and holds until the next MREAD.
  - This matches the CPU issuing MREAD in IF1 and loading IR at the end of IF2.
- A write completes at the sampling edge. A read of the same address on the following cycle returns the new value; there is no bypass hazard, because the bus carries one command per cycle.
- A `SW` change becomes visible to a read sampled at edge N+2 or later, where edge N is the first edge that sees the new value.
- `cpu_reset` is registered. It rises on the first edge with `reset`=1, stays high through LOAD, and falls on the edge that completes the load. The CPU first sees `cpu_reset`=0 in the cycle after the last boot word.
- `load_done` rises on the same edge that `cpu_reset` falls.
- Reset asserted mid-LOAD or mid-RUN:
  - Returns to LOAD with `load_ptr`=0.
  - Any LOAD-state write in that same cycle is suppressed, because reset has priority.
  - A RUN-state write in that same cycle is also suppressed.
- `load_ptr` wrap: the 256th consecutive word ends the load even if `load_last`=0.

## Test plan
- Boot load: reset, then 4 words 16'hD105, 16'hD202, 16'hA023, 16'hE000 with `load_last` on the 4th. Required: RAM[0..3] hold those words, `cpu_reset` falls and `load_done` rises exactly one edge after word 4, `load_ptr`=4.
- Read latency and hold: in RUN, MWRITE addr 9'h010 data 16'hBEEF, next cycle MREAD 9'h010. Required: `read_data`=16'hBEEF the cycle after the MREAD, unchanged over 3 following idle cycles.
- Memory-mapped I/O: MWRITE 9'h100 data 16'h12A5 gives `LEDR`=8'hA5. With `SW`=8'h3C held, MREAD 9'h140 gives `read_data`=16'h003C. A `SW` change seen at edge N is read back only from edge N+2.
- Bad access: MREAD 9'h1FF gives `read_data`=0 and `bad_access`=1. A subsequent MWRITE 9'h180 leaves RAM and `LEDR` untouched. `bad_access` stays 1 until reset. `mem_cmd`=2'b11 also sets it.
- 256-word load without `load_last`: words 0..255 written. Required: transition to RUN after word 255 and `load_ptr` wraps to 0. A 257th `load_valid` is ignored and RAM[0] is unchanged.
- Reset mid-load after 2 words, with `load_valid` asserted in the reset cycle: the reset-cycle word is not written, `cpu_reset`=1, `load_ptr`=0, and RAM[0..1] keep their old contents until reloaded.
